// File: rtl/seq_control_if.sv
// Control/status bundle between the sequencer and the datapath around it.
// Handshake: there is no valid/ready pair here; every input is a level that
// the sequencer samples on each rising clk edge, and every output is a
// register that changes only on a rising clk edge.
interface seq_control_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              start;
  logic              step_mode;
  logic              step;
  logic [ADDR_W-1:0] new_pc;
  logic              imem_er;
  logic              ins_er;
  logic              hlt;
  logic              dmem_er;
  logic [ADDR_W-1:0] pc;
  logic [5:0]        stage_en;
  logic [2:0]        stat;
  logic              running;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  instr_cnt;
  logic [3:0]        state_dbg;

  // Datapath / environment side.
  modport master (
    output start, step_mode, step, new_pc, imem_er, ins_er, hlt, dmem_er,
    input  pc, stage_en, stat, running, cycle_cnt, instr_cnt, state_dbg
  );

  // Sequencer side.
  modport slave (
    input  start, step_mode, step, new_pc, imem_er, ins_er, hlt, dmem_er,
    output pc, stage_en, stat, running, cycle_cnt, instr_cnt, state_dbg
  );
endinterface

// File: rtl/seq_control.sv
// Y86-style multi-cycle sequencer: walks FET..PCU one state per cycle,
// supports single-stepping, halts on fetch/memory faults or a halt opcode,
// and keeps saturating cycle / retired-instruction counters.
module seq_control #(
  parameter int ADDR_W     = 64,
  parameter int IMEM_DEPTH = 2048,
  parameter int CNT_W      = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_control_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FET    = 4'd1,
    S_DEC    = 4'd2,
    S_EXE    = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_PCU    = 4'd6,
    S_PAUSE  = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Wide enough to hold both pc and IMEM_DEPTH without truncating either.
  localparam int XW = (ADDR_W > 32) ? ADDR_W : 33;
  localparam logic [XW-1:0] DEPTH_X = XW'($unsigned(IMEM_DEPTH));

  state_t           state;
  logic [ADDR_W-1:0] pc_q;
  logic [5:0]       stage_en_q;
  logic [2:0]       stat_q;
  logic             running_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  logic pc_out_of_range;
  assign pc_out_of_range = (XW'(pc_q) >= DEPTH_X);

  // Sequencer FSM with registered outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc_q       <= '0;
      stage_en_q <= '0;
      stat_q     <= STAT_AOK;
      running_q  <= 1'b0;
      cycle_q    <= '0;
      instr_q    <= '0;
    end else begin
      // running_q is high exactly in the stage states, so this counts the
      // edge that leaves each stage state, including the one into HALTED.
      if (running_q && (cycle_q != '1)) begin
        cycle_q <= cycle_q + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_FET;
            stage_en_q <= 6'b000001;
            running_q  <= 1'b1;
          end
        end
        S_FET: begin
          if (bus.imem_er || pc_out_of_range) begin
            state      <= S_HALTED;
            stat_q     <= STAT_ADR;
            stage_en_q <= '0;
            running_q  <= 1'b0;
          end else if (bus.ins_er) begin
            state      <= S_HALTED;
            stat_q     <= STAT_INS;
            stage_en_q <= '0;
            running_q  <= 1'b0;
          end else if (bus.hlt) begin
            state      <= S_HALTED;
            stat_q     <= STAT_HLT;
            stage_en_q <= '0;
            running_q  <= 1'b0;
          end else begin
            state      <= S_DEC;
            stage_en_q <= 6'b000010;
          end
        end
        S_DEC: begin
          state      <= S_EXE;
          stage_en_q <= 6'b000100;
        end
        S_EXE: begin
          state      <= S_MEM;
          stage_en_q <= 6'b001000;
        end
        S_MEM: begin
          if (bus.dmem_er) begin
            state      <= S_HALTED;
            stat_q     <= STAT_ADR;
            stage_en_q <= '0;
            running_q  <= 1'b0;
          end else begin
            state      <= S_WB;
            stage_en_q <= 6'b010000;
          end
        end
        S_WB: begin
          state      <= S_PCU;
          stage_en_q <= 6'b100000;
        end
        S_PCU: begin
          pc_q <= bus.new_pc;
          if (instr_q != '1) begin
            instr_q <= instr_q + 1'b1;
          end
          if (bus.step_mode) begin
            state      <= S_PAUSE;
            stage_en_q <= '0;
            running_q  <= 1'b0;
          end else begin
            state      <= S_FET;
            stage_en_q <= 6'b000001;
          end
        end
        S_PAUSE: begin
          if (bus.step) begin
            state      <= S_FET;
            stage_en_q <= 6'b000001;
            running_q  <= 1'b1;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state      <= S_IDLE;
          stage_en_q <= '0;
          running_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.stage_en  = stage_en_q;
  assign bus.stat      = stat_q;
  assign bus.running   = running_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;
  assign bus.state_dbg = state;

endmodule
